round_sat_pipe: RTL and testbench
=================================

ROUND_SAT_PIPE -- requirements
Module: round_sat_pipe

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: signed two's-complement input sample width per channel.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: signed output sample width per channel.
REQ-003 SHALL have parameter LSB_DROP, default 8: number of LSBs removed by rounding; 0 allowed.
REQ-004 SHALL have parameter CH_NUM, default 2: number of parallel channels (e.g. I/Q).
REQ-005 SHALL have parameter SYM_SAT, default 0: 1 clips negative full-scale to -(2^(OUT_WIDTH-1)-1).
REQ-006 SHALL have parameter CNT_WIDTH, default 16: saturation event counter width.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 din  input  CH_NUM*IN_WIDTH  packed samples; channel k occupies bits [k*IN_WIDTH +: IN_WIDTH].
REQ-010 din_vld  input  1  din qualifier.
REQ-011 rnd_mode  input  2  00 truncate (floor), 01 round-half-up, 10 convergent (round-half-even), 11 treated as 00.
REQ-012 sat_clr  input  1  synchronous clear of sat_cnt and sat_flag.
REQ-013 dout  output  CH_NUM*OUT_WIDTH  packed results, same channel order as din.
REQ-014 dout_vld  output  1  dout qualifier.
REQ-015 dout_sat  output  CH_NUM  per-channel saturation indicator aligned with dout.
REQ-016 sat_flag  output  1  sticky: any channel saturated since reset or last sat_clr.
REQ-017 sat_cnt  output  CNT_WIDTH  count of valid output beats with any channel saturated.

Function
REQ-018 SHALL require IN_WIDTH >= OUT_WIDTH + LSB_DROP; elaboration fails otherwise.
REQ-019 Stage 1 SHALL register, per channel, din with the rounding increment applied, extended to IN_WIDTH+1 bits so the increment never wraps.
REQ-020 Round-half-up SHALL add 2^(LSB_DROP-1) before discarding LSB_DROP bits; truncate SHALL add 0.
REQ-021 Convergent SHALL add 2^(LSB_DROP-1) unless dropped bits equal exactly one half and the retained LSB is 0, in which case it SHALL add 0.
REQ-022 With LSB_DROP = 0, all rounding modes SHALL be identical pass-through of the value.
REQ-023 rnd_mode SHALL be sampled together with din on each din_vld beat; a mode change applies only to samples accepted after it.
REQ-024 Stage 2 SHALL register the saturated result: value above 2^(OUT_WIDTH-1)-1 gives 0x7FF..F; value below the negative limit gives the negative limit (0x80..0, or 0x80..1 when SYM_SAT=1); otherwise the retained bits unchanged.
REQ-025 Overflow caused by the rounding increment itself SHALL saturate and set dout_sat.
REQ-026 dout_sat[k] SHALL be 1 exactly when channel k's value was clipped, including -2^(OUT_WIDTH-1) clipped under SYM_SAT=1.
REQ-027 Latency SHALL be 2 clk cycles from din_vld to dout_vld; one beat per cycle, no back-pressure.
REQ-028 dout and dout_sat SHALL hold their last values while dout_vld is 0.
REQ-029 sat_cnt SHALL increment by 1 on each dout_vld beat with any dout_sat bit set, and SHALL hold at 2^CNT_WIDTH-1 (no wrap).
REQ-030 sat_flag SHALL set on the same beat as the sat_cnt increment.
REQ-031 sat_clr SHALL take priority over a simultaneous saturation event: next value is sat_cnt=0, sat_flag=0.

Reset
REQ-032 rst SHALL asynchronously force dout=0, dout_vld=0, dout_sat=0, sat_flag=0, sat_cnt=0, and clear all pipeline registers and valid bits.
REQ-033 Samples in flight when rst asserts SHALL be discarded; no dout_vld pulse appears for them after release.

Structure
REQ-034 Rounding-mode encodings (RND_TRUNC, RND_HALF_UP, RND_CONV) SHALL be defined as constants in the shared cbb_comm package.
REQ-035 Per-channel round-and-saturate datapath SHALL be a sub-module round_sat_ch instantiated CH_NUM times by generate; the counter, sticky flag and valid pipeline live in the top.

Verification (IN_WIDTH=32, OUT_WIDTH=16, LSB_DROP=8, CH_NUM=2)
REQ-036 din ch0=0x00001280 in modes 00/01/10 -> dout ch0 0x0012 / 0x0013 / 0x0012; ch0=0x00001380 in mode 10 -> 0x0014; dout_sat=0; dout_vld exactly 2 cycles later.
REQ-037 ch0=0x00800000, ch1=0xFF7FFFFF -> ch0 0x7FFF, ch1 0x8000, dout_sat=2'b11, sat_cnt +1 (once per beat, not per channel).
REQ-038 ch0=0x007FFF80 in mode 01 -> 0x7FFF with dout_sat[0]=1; in mode 00 -> 0x7FFF with dout_sat[0]=0.
REQ-039 ch0=0xFF800000 -> 0x8000, sat=0 with SYM_SAT=0; 0x8001, sat=1 with SYM_SAT=1.
REQ-040 CNT_WIDTH=4, 20 consecutive saturating beats -> sat_cnt holds at 0xF; sat_clr on a saturating beat -> sat_cnt=0, sat_flag=0.
REQ-041 rst asserted one cycle after a din_vld beat -> all outputs 0 immediately; no dout_vld after release.

Source files
------------

// File: rtl/cbb_comm_pkg.sv
// Shared common-building-block constants: rounding-mode encodings used by
// the round/saturate datapaths.
package cbb_comm;

    localparam int unsigned RND_MODE_W = 2;

    localparam logic [RND_MODE_W-1:0] RND_TRUNC   = 2'b00;
    localparam logic [RND_MODE_W-1:0] RND_HALF_UP = 2'b01;
    localparam logic [RND_MODE_W-1:0] RND_CONV    = 2'b10;

endpackage

// File: rtl/round_sat_pipe_ch.sv
// One channel of the round/saturate datapath: stage 1 adds the rounding
// increment in IN_WIDTH+1 bits, stage 2 drops LSBs and clips to OUT_WIDTH.
module round_sat_ch
    import cbb_comm::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned LSB_DROP  = 8,
    parameter bit          SYM_SAT   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld1,
    input  logic                  ld2,
    input  logic [IN_WIDTH-1:0]   din,
    input  logic [RND_MODE_W-1:0] rnd_mode,
    output logic [OUT_WIDTH-1:0]  dout,
    output logic                  sat,
    output logic                  sat_c
);

    localparam int unsigned EXT_W = IN_WIDTH + 1;
    localparam int unsigned VAL_W = EXT_W - LSB_DROP;

    localparam logic signed [VAL_W-1:0] POS_FS =
        {{(VAL_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [VAL_W-1:0] NEG_FS =
        {{(VAL_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [VAL_W-1:0] NEG_LIM =
        SYM_SAT ? NEG_FS + VAL_W'(1) : NEG_FS;

    logic [EXT_W-1:0]        inc;
    logic [EXT_W-1:0]        acc;
    logic signed [VAL_W-1:0] val;
    logic [OUT_WIDTH-1:0]    res_c;

    if (LSB_DROP == 0) begin : g_no_rnd
        logic unused_mode;
        assign unused_mode = ^rnd_mode;
        assign inc = '0;
    end else begin : g_rnd
        localparam logic [EXT_W-1:0] HALF = EXT_W'(1) << (LSB_DROP - 1);

        logic half_tie;
        logic unused_lsb;

        // Exact half with an even retained LSB stays put under convergent rounding
        assign half_tie   = (din[LSB_DROP-1:0] == HALF[LSB_DROP-1:0]) && !din[LSB_DROP];
        assign unused_lsb = ^acc[LSB_DROP-1:0];

        always_comb begin
            inc = '0;
            case (rnd_mode)
                RND_HALF_UP: inc = HALF;
                RND_CONV:    inc = half_tie ? '0 : HALF;
                default:     inc = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (ld1) begin
            acc <= {din[IN_WIDTH-1], din} + inc;
        end
    end

    assign val = signed'(acc[EXT_W-1:LSB_DROP]);

    always_comb begin
        res_c = val[OUT_WIDTH-1:0];
        sat_c = 1'b0;
        if (val > POS_FS) begin
            res_c = POS_FS[OUT_WIDTH-1:0];
            sat_c = 1'b1;
        end else if (val < NEG_LIM) begin
            res_c = NEG_LIM[OUT_WIDTH-1:0];
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            sat  <= 1'b0;
        end else if (ld2) begin
            dout <= res_c;
            sat  <= sat_c;
        end
    end

endmodule

// File: rtl/round_sat_pipe.sv
// Multi-channel two-stage round-and-saturate pipeline with a sticky
// saturation flag and a non-wrapping saturation beat counter.
module round_sat_pipe
    import cbb_comm::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned LSB_DROP  = 8,
    parameter int unsigned CH_NUM    = 2,
    parameter bit          SYM_SAT   = 1'b0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CH_NUM*IN_WIDTH-1:0]  din,
    input  logic                        din_vld,
    input  logic [RND_MODE_W-1:0]       rnd_mode,
    input  logic                        sat_clr,
    output logic [CH_NUM*OUT_WIDTH-1:0] dout,
    output logic                        dout_vld,
    output logic [CH_NUM-1:0]           dout_sat,
    output logic                        sat_flag,
    output logic [CNT_WIDTH-1:0]        sat_cnt
);

    if (IN_WIDTH < OUT_WIDTH + LSB_DROP) begin : g_bad_cfg
        $error("round_sat_pipe: IN_WIDTH must be >= OUT_WIDTH + LSB_DROP");
    end

    logic              vld1;
    logic [CH_NUM-1:0] sat_c;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        round_sat_ch #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .LSB_DROP  (LSB_DROP),
            .SYM_SAT   (SYM_SAT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .ld1      (din_vld),
            .ld2      (vld1),
            .din      (din[k*IN_WIDTH +: IN_WIDTH]),
            .rnd_mode (rnd_mode),
            .dout     (dout[k*OUT_WIDTH +: OUT_WIDTH]),
            .sat      (dout_sat[k]),
            .sat_c    (sat_c[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1     <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            vld1     <= din_vld;
            dout_vld <= vld1;
        end
    end

    // Counter and flag update on the edge that registers the beat, so they line up with dout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt  <= '0;
            sat_flag <= 1'b0;
        end else if (sat_clr) begin
            sat_cnt  <= '0;
            sat_flag <= 1'b0;
        end else if (vld1 && (|sat_c)) begin
            sat_flag <= 1'b1;
            if (sat_cnt != '1) begin
                sat_cnt <= sat_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Scoreboard bench for round_sat_pipe: directed vectors push expected beats,
// a negedge monitor pops and compares every dout_vld beat.
`timescale 1ns/1ps
module tb_round_sat_pipe;

    localparam int unsigned IW = 32;
    localparam int unsigned OW = 16;
    localparam int unsigned CH = 2;
    localparam int unsigned CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*IW-1:0] din;
    logic             din_vld;
    logic [1:0]       rnd_mode;
    logic             sat_clr;

    logic [CH*OW-1:0] dout_a, dout_b;
    logic             dout_vld_a, dout_vld_b;
    logic [CH-1:0]    sat_a, sat_b;
    logic             flag_a, b_flag_unused;
    logic [CW-1:0]    cnt_a, b_cnt_unused;

    always #5 clk = ~clk;

    round_sat_pipe #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_DROP(8), .CH_NUM(CH),
        .SYM_SAT(1'b0), .CNT_WIDTH(CW)
    ) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .rnd_mode(rnd_mode),
        .sat_clr(sat_clr), .dout(dout_a), .dout_vld(dout_vld_a), .dout_sat(sat_a),
        .sat_flag(flag_a), .sat_cnt(cnt_a)
    );

    round_sat_pipe #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_DROP(8), .CH_NUM(CH),
        .SYM_SAT(1'b1), .CNT_WIDTH(CW)
    ) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .rnd_mode(rnd_mode),
        .sat_clr(sat_clr), .dout(dout_b), .dout_vld(dout_vld_b), .dout_sat(sat_b),
        .sat_flag(b_flag_unused), .sat_cnt(b_cnt_unused)
    );

    typedef struct {
        logic [31:0] dout;
        logic [1:0]  sat;
        logic [3:0]  cnt;
        logic        flag;
        logic        b_chk;
        logic [31:0] b_dout;
        logic [1:0]  b_sat;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int   exp_cnt   = 0;
    logic exp_flag  = 1'b0;
    logic clr_next  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on every valid beat, and checks outputs hold between beats
    logic [31:0] last_dout = '0;
    logic [1:0]  last_sat  = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_dout = '0;
            last_sat  = '0;
        end else if (dout_vld_a) begin
            if (sbq.size() == 0) begin
                check("unexpected_dout_vld", 64'(dout_vld_a), 64'(0));
            end else begin
                e = sbq.pop_front();
                check("latency", 64'(cyc), 64'(e.cyc + 2));
                check("dout", 64'(dout_a), 64'(e.dout));
                check("dout_sat", 64'(sat_a), 64'(e.sat));
                check("sat_cnt", 64'(cnt_a), 64'(e.cnt));
                check("sat_flag", 64'(flag_a), 64'(e.flag));
                check("vld_b", 64'(dout_vld_b), 64'(1));
                if (e.b_chk) begin
                    check("dout_sym", 64'(dout_b), 64'(e.b_dout));
                    check("dout_sat_sym", 64'(sat_b), 64'(e.b_sat));
                end
            end
            last_dout = dout_a;
            last_sat  = sat_a;
        end else begin
            check("hold_dout", 64'(dout_a), 64'(last_dout));
            check("hold_sat", 64'(sat_a), 64'(last_sat));
        end
    end

    // One input beat; clr pulses sat_clr on the edge that registers this beat's output
    task automatic issue(input logic [31:0] c0, input logic [31:0] c1, input logic [1:0] m,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [1:0] es,
                         input logic clr = 1'b0, input logic bchk = 1'b0,
                         input logic [15:0] b0 = '0, input logic [15:0] b1 = '0,
                         input logic [1:0] bs = '0);
        exp_t e;
        @(posedge clk); #1;
        din      = {c1, c0};
        din_vld  = 1'b1;
        rnd_mode = m;
        sat_clr  = clr_next;
        clr_next = clr;
        if (clr) begin
            exp_cnt  = 0;
            exp_flag = 1'b0;
        end else if (es != 2'b00) begin
            exp_flag = 1'b1;
            if (exp_cnt < 15) exp_cnt++;
        end
        e.dout   = {e1, e0};
        e.sat    = es;
        e.cnt    = 4'(exp_cnt);
        e.flag   = exp_flag;
        e.b_chk  = bchk;
        e.b_dout = {b1, b0};
        e.b_sat  = bs;
        e.cyc    = cyc;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            din      = {32'hDEADBEEF, 32'h5A5A5A5A};
            din_vld  = 1'b0;
            rnd_mode = 2'b01;
            sat_clr  = clr_next;
            clr_next = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        din      = '0;
        din_vld  = 1'b0;
        rnd_mode = 2'b00;
        sat_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 64'(dout_a), 64'(0));
        check("rst_vld", 64'(dout_vld_a), 64'(0));
        check("rst_sat", 64'(sat_a), 64'(0));
        check("rst_cnt", 64'(cnt_a), 64'(0));
        check("rst_flag", 64'(flag_a), 64'(0));
        rst = 1'b0;
        idle(2);

        // Rounding modes, including a per-beat mode change
        issue(32'h00001280, 32'hFFFFFF80, 2'b00, 16'h0012, 16'hFFFF, 2'b00);
        issue(32'h00001280, 32'hFFFFFF80, 2'b01, 16'h0013, 16'h0000, 2'b00);
        issue(32'h00001280, 32'hFFFFFF80, 2'b10, 16'h0012, 16'h0000, 2'b00);
        issue(32'h00001380, 32'hFFFFFE80, 2'b10, 16'h0014, 16'hFFFE, 2'b00);
        // Saturation both ways, and overflow from the rounding increment
        issue(32'h00800000, 32'hFF7FFFFF, 2'b00, 16'h7FFF, 16'h8000, 2'b11,
              1'b0, 1'b1, 16'h7FFF, 16'h8001, 2'b11);
        issue(32'h007FFF80, 32'h00000000, 2'b01, 16'h7FFF, 16'h0000, 2'b01);
        issue(32'h007FFF80, 32'h00000000, 2'b00, 16'h7FFF, 16'h0000, 2'b00);
        idle(2);
        // Negative full scale: passes unless symmetric clipping
        issue(32'hFF800000, 32'h007FFFFF, 2'b00, 16'h8000, 16'h7FFF, 2'b00,
              1'b0, 1'b1, 16'h8001, 16'h7FFF, 2'b01);
        issue(32'h000000FF, 32'h0000017F, 2'b01, 16'h0001, 16'h0001, 2'b00);
        issue(32'h00001280, 32'hFFFFFF80, 2'b11, 16'h0012, 16'hFFFF, 2'b00);
        issue(32'h00001181, 32'h00001380, 2'b10, 16'h0012, 16'h0014, 2'b00);
        idle(3);

        // Counter saturates at 15, then clear wins over a saturating beat
        for (int i = 0; i < 20; i++) begin
            issue(32'h00800000, 32'h00000000, 2'b00, 16'h7FFF, 16'h0000, 2'b01);
        end
        issue(32'h00800000, 32'h00000000, 2'b00, 16'h7FFF, 16'h0000, 2'b01, 1'b1);
        issue(32'h00800000, 32'h00000000, 2'b00, 16'h7FFF, 16'h0000, 2'b01);
        issue(32'h00001280, 32'h00000000, 2'b01, 16'h0013, 16'h0000, 2'b00, 1'b1);
        idle(3);

        // Reset with a beat in flight
        issue(32'h00800000, 32'h00000000, 2'b00, 16'h7FFF, 16'h0000, 2'b01);
        idle(3);
        issue(32'h00001280, 32'hFFFFFF80, 2'b01, 16'h0013, 16'h0000, 2'b00);
        @(posedge clk); #1;
        din_vld = 1'b0;
        rst     = 1'b1;
        #1;
        check("arst_dout", 64'(dout_a), 64'(0));
        check("arst_vld", 64'(dout_vld_a), 64'(0));
        check("arst_sat", 64'(sat_a), 64'(0));
        check("arst_cnt", 64'(cnt_a), 64'(0));
        check("arst_flag", 64'(flag_a), 64'(0));
        sbq.delete();
        exp_cnt  = 0;
        exp_flag = 1'b0;
        clr_next = 1'b0;
        sat_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        issue(32'h00001380, 32'hFFFFFE80, 2'b10, 16'h0014, 16'hFFFE, 2'b00);
        idle(1);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(sbq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
